dbus_ctrl: RTL and testbench
============================

# dbus_ctrl

Data-bus controller sitting directly downstream of the execute-stage memory unit. It accepts one word-aligned load/store request at a time over a decoupled request channel and drives an external strobe/acknowledge data bus with arbitrary wait states. It returns exactly one response word per accepted request, including stores. It also honours pipeline flush by completing, then discarding, any in-flight transaction.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256, bus cycles to wait for `bus_ack` before aborting; used only with DBUS_TIMEOUT_EN; must be ≥2.
- ERR_DATA, 32'hFFFF_FFFF, response word returned on timeout abort.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req  decoupled.in  mem_req_t  {a[31:0] word-aligned, we, be[3:0], d[31:0]}
- resp  decoupled.out  mtrans  32-bit read data (0 for stores)
- flush  in  1  discard pending/in-flight response
- bus_stb  out  1  bus request strobe
- bus_we  out  1  write enable
- bus_addr  out  32  address, registered at acceptance
- bus_be  out  4  byte enables
- bus_wdata  out  32  write data
- bus_ack  in  1  transaction complete this cycle
- bus_rdata  in  32  read data, valid with `bus_ack`
- bus_err  out  1  sticky timeout flag; exists only with DBUS_TIMEOUT_EN

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `req.ready = !flush`. When `req` fires, register a/we/be/d onto the bus outputs and go to BUS. Clear `drop`.
- BUS: `bus_stb = 1`, bus outputs held stable. On `bus_ack`:
  - capture `bus_rdata`, or 0 if `we`, into the response register;
  - if `drop` or `flush` is set, go to IDLE; otherwise go to RESP.
- `flush` in BUS sets `drop`. The bus cycle is never abandoned mid-strobe, except by timeout.
- RESP: `resp.valid = 1` and the data is held. On `resp.ready`, go to IDLE. On `flush`, go to IDLE with no handshake; `flush` wins over `resp.ready` in the same cycle.
- Not ready for a new request in BUS or RESP. At most one transaction is outstanding.
- `bus_ack` outside BUS is ignored.

## Timing
- Reset values: state=IDLE, `bus_stb`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `resp.valid`=0, resp data=0, `drop`=0, `bus_err`=0. `req.ready` becomes 1 once reset deasserts, subject to `flush`.
- Reset asserted mid-transaction: immediate return to IDLE, `bus_stb` drops asynchronously, the transaction is lost.
- `req` fires in cycle N. `bus_stb` is high from N+1.
- `bus_ack` in cycle M ≥ N+1 gives `resp.valid` in M+1.
- Minimum request-to-response latency is 2 cycles. Back-to-back throughput is 1 request per 3 cycles with zero wait states and immediate `resp.ready`.
- `bus_*` outputs are registered; no combinational path from `bus_ack` to `bus_stb`.
- `resp.valid` and resp data come straight from registers. `req.ready` depends combinationally only on state and `flush`.

## Configuration
- DBUS_TIMEOUT_EN defined:
  - a counter runs in BUS, clears on entry;
  - when it reaches TIMEOUT_CYCLES-1 without `bus_ack`, drop `bus_stb` next cycle, load ERR_DATA as the response, set `bus_err` (sticky until reset), and go to RESP, or to IDLE if `drop`;
  - `bus_ack` in the expiry cycle takes priority: normal completion, no error.
- Undefined: no counter, no `bus_err` port; BUS waits indefinitely.

## Structure
- Shared types package: `mem_req_t`, `mtrans`, and a `dbus_state_e` enum (IDLE, BUS, RESP).
- ERR_DATA default constant lives in the package.
- One sub-module, `dbus_watchdog`: counter plus expiry pulse, instantiated only under DBUS_TIMEOUT_EN. The FSM stays in `dbus_ctrl`.

## Test plan
- Load a=0x100, `bus_ack` 3 cycles after strobe with rdata=0xDEADBEEF → `resp.valid` one cycle after ack with 0xDEADBEEF; `bus_be`/`bus_addr` stable throughout the strobe.
- Store a=0x204, be=4'b1100, d=0x12340000, zero-wait ack → `bus_we`=1, `bus_wdata`=0x12340000, resp data=0, latency 2 cycles.
- `flush` pulsed during BUS, ack 2 cycles later → no `resp.valid`; `req.ready`=1 the cycle after ack.
- `resp.ready` held low 5 cycles in RESP → data and valid stable; `req.ready`=0 until the handshake; `flush` plus `resp.ready` same cycle → IDLE, no retire.
- `rst_n` low while `bus_stb`=1 → `bus_stb`=0 asynchronously; after release, a new load completes normally.
- DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack → `bus_stb` drops after 8 strobe cycles, resp=0xFFFFFFFF, `bus_err`=1 and stays set; ack on the 8th cycle → normal data, `bus_err`=0.

Source files
------------

// File: rtl/dbus_ctrl_pkg.sv
// rtl/dbus_ctrl_pkg.sv - shared request/response types, FSM state enum and error word for dbus_ctrl
package dbus_ctrl_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
    } mem_req_t;

    typedef logic [31:0] mtrans;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } dbus_state_e;

    localparam mtrans DBUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbus_watchdog.sv
// rtl/dbus_watchdog.sv - bus-cycle counter that pulses expire on the last allowed strobe cycle
module dbus_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // Held at zero outside a strobe, so every bus cycle starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expire = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - single-outstanding load/store bus controller with flush discard
// Optional strobe timeout and sticky bus_err enabled by defining DBUS_TIMEOUT_EN.
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = 256,
    parameter mtrans ERR_DATA       = DBUS_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_tvalid,
    output logic        req_tready,
    input  mem_req_t    req_tdata,
    output logic        resp_tvalid,
    input  logic        resp_tready,
    output mtrans       resp_tdata,
    input  logic        flush,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef DBUS_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    dbus_state_e state, state_d;
    logic        drop;
    logic        req_fire;
    logic        timeout;

    assign req_tready = (state == IDLE) && !flush;
    assign req_fire   = req_tvalid && req_tready;

`ifdef DBUS_TIMEOUT_EN
    logic wd_expire;

    dbus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == BUS),
        .expire (wd_expire)
    );

    // An ack landing in the expiry cycle completes normally.
    assign timeout = wd_expire && !bus_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = (^ERR_DATA) ^ (TIMEOUT_CYCLES > 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (req_fire) state_d = BUS;
            BUS:  if (bus_ack || timeout) state_d = (drop || flush) ? IDLE : RESP;
            RESP: if (flush || resp_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe and valid are flops fed from the next state, keeping bus_ack off any output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_stb     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            resp_tvalid <= 1'b0;
            resp_tdata  <= '0;
            drop        <= 1'b0;
        end else begin
            bus_stb     <= (state_d == BUS);
            resp_tvalid <= (state_d == RESP);
            if (req_fire) begin
                bus_addr  <= req_tdata.a;
                bus_we    <= req_tdata.we;
                bus_be    <= req_tdata.be;
                bus_wdata <= req_tdata.d;
                drop      <= 1'b0;
            end else if (state == BUS && flush) begin
                drop <= 1'b1;
            end
            if (state == BUS && bus_ack) begin
                resp_tdata <= bus_we ? '0 : bus_rdata;
            end else if (timeout) begin
                resp_tdata <= ERR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - scoreboard bench for dbus_ctrl (timeout cases with DBUS_TIMEOUT_EN)
module tb_dbus_ctrl;
    import dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_tvalid;
    logic        req_tready;
    mem_req_t    req_tdata;
    logic        resp_tvalid;
    logic        resp_tready;
    mtrans       resp_tdata;
    logic        flush;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef DBUS_TIMEOUT_EN
    logic        bus_err;
`endif

    int    checks   = 0;
    int    failures = 0;
    mtrans exp_q[$];

    always #5 clk = ~clk;

    dbus_ctrl #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_tvalid  (req_tvalid),
        .req_tready  (req_tready),
        .req_tdata   (req_tdata),
        .resp_tvalid (resp_tvalid),
        .resp_tready (resp_tready),
        .resp_tdata  (resp_tdata),
        .flush       (flush),
        .bus_stb     (bus_stb),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
`ifdef DBUS_TIMEOUT_EN
        ,
        .bus_err     (bus_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
        logic fired;
        fired = 1'b0;
        req_tdata.a  = addr;
        req_tdata.we = we;
        req_tdata.be = be;
        req_tdata.d  = wd;
        req_tvalid   = 1'b1;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            if (req_tready) fired = 1'b1;
        end
        check("req_accept", fired, 1);
        tick();
        req_tvalid = 1'b0;
    endtask

    task automatic zero_wait_ack(input logic [31:0] rd);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    // Scoreboard: a retire is valid && ready with no flush in the same cycle.
    always @(negedge clk) begin
        if (rst_n && resp_tvalid && resp_tready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h expected=none", resp_tdata);
            end else begin
                check("resp_data", resp_tdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n       = 1'b0;
        req_tvalid  = 1'b0;
        req_tdata   = '0;
        resp_tready = 1'b1;
        flush       = 1'b0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stb", bus_stb, 0);
        check("rst_we", bus_we, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_be", bus_be, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_resp_valid", resp_tvalid, 0);
        check("rst_resp_data", resp_tdata, 0);
`ifdef DBUS_TIMEOUT_EN
        check("rst_bus_err", bus_err, 0);
`endif
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", req_tready, 1);
        flush = 1'b1;
        #1;
        check("idle_ready_flush", req_tready, 0);
        flush = 1'b0;

        // Stray ack while idle must be ignored.
        tick();
        zero_wait_ack(32'h0BAD_0BAD);
        @(negedge clk);
        check("stray_ack_stb", bus_stb, 0);
        check("stray_ack_valid", resp_tvalid, 0);
        tick();

        // Load with three wait states.
        exp_q.push_back(32'hDEAD_BEEF);
        issue(32'h100, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_stb", bus_stb, 1);
            check("t1_addr", bus_addr, 32'h100);
            check("t1_be", bus_be, 4'hF);
            check("t1_we", bus_we, 0);
            tick();
        end
        zero_wait_ack(32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_resp_valid", resp_tvalid, 1);
        check("t1_stb_drop", bus_stb, 0);
        tick();

        // Zero-wait store: response one cycle after ack, two after acceptance.
        exp_q.push_back(32'h0);
        issue(32'h204, 1'b1, 4'b1100, 32'h1234_0000);
        @(negedge clk);
        check("t2_stb", bus_stb, 1);
        check("t2_we", bus_we, 1);
        check("t2_wdata", bus_wdata, 32'h1234_0000);
        check("t2_be", bus_be, 4'b1100);
        check("t2_addr", bus_addr, 32'h204);
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        tick();
        bus_ack   = 1'b0;
        @(negedge clk);
        check("t2_latency_valid", resp_tvalid, 1);
        tick();

        // Flush during BUS: ack still completes the strobe but no response.
        issue(32'h300, 1'b0, 4'hF, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        zero_wait_ack(32'h5555_5555);
        @(negedge clk);
        check("t3_no_valid", resp_tvalid, 0);
        check("t3_ready_after_ack", req_tready, 1);
        check("t3_stb_drop", bus_stb, 0);
        tick();
        @(negedge clk);
        check("t3_still_no_valid", resp_tvalid, 0);
        tick();

        // Backpressure in RESP, then a flush racing resp_tready.
        resp_tready = 1'b0;
        exp_q.push_back(32'hCAFE_F00D);
        issue(32'h400, 1'b0, 4'hF, 32'h0);
        zero_wait_ack(32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", resp_tvalid, 1);
            check("t4_hold_data", resp_tdata, 32'hCAFE_F00D);
            check("t4_hold_not_ready", req_tready, 0);
            tick();
        end
        resp_tready = 1'b1;
        tick();
        @(negedge clk);
        check("t4_retired", resp_tvalid, 0);
        resp_tready = 1'b0;
        tick();
        issue(32'h404, 1'b0, 4'hF, 32'h0);
        zero_wait_ack(32'h0BAD_F00D);
        @(negedge clk);
        check("t4b_valid", resp_tvalid, 1);
        tick();
        flush       = 1'b1;
        resp_tready = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t4b_flushed", resp_tvalid, 0);
        check("t4b_idle_ready", req_tready, 1);
        tick();

        // Asynchronous reset mid-strobe, then a normal load.
        issue(32'h500, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("t5_stb_before_rst", bus_stb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_stb", bus_stb, 0);
        check("t5_async_valid", resp_tvalid, 0);
        tick();
        rst_n = 1'b1;
        exp_q.push_back(32'h1122_3344);
        issue(32'h504, 1'b0, 4'hF, 32'h0);
        zero_wait_ack(32'h1122_3344);
        @(negedge clk);
        check("t5_resp_valid", resp_tvalid, 1);
        tick();

`ifdef DBUS_TIMEOUT_EN
        // Ack on the eighth strobe cycle wins over expiry.
        exp_q.push_back(32'hA5A5_A5A5);
        issue(32'h600, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        zero_wait_ack(32'hA5A5_A5A5);
        @(negedge clk);
        check("t6_ack_last_valid", resp_tvalid, 1);
        check("t6_ack_last_err", bus_err, 0);
        tick();

        // No ack: strobe drops after eight cycles with the error word.
        exp_q.push_back(32'hFFFF_FFFF);
        issue(32'h700, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t7_stb", bus_stb, 1);
            tick();
        end
        @(negedge clk);
        check("t7_stb_drop", bus_stb, 0);
        check("t7_valid", resp_tvalid, 1);
        check("t7_err", bus_err, 1);
        tick();
        exp_q.push_back(32'h0000_1234);
        issue(32'h800, 1'b0, 4'hF, 32'h0);
        zero_wait_ack(32'h0000_1234);
        @(negedge clk);
        check("t7_err_sticky", bus_err, 1);
        tick();
`endif

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
